// File: rtl/square_draw_arbiter_if.sv
// Requester and square-engine signal bundle for square_draw_arbiter.
interface square_draw_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_x;
  logic [7*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]   req_draw;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic                 busy;
  logic                 sq_go;
  logic                 sq_plot;
  logic [7:0]           sq_x;
  logic [6:0]           sq_y;
  logic [2:0]           sq_colour;
  logic                 sq_draw;

  modport master (
    output req, req_x, req_y, req_colour, req_draw, sq_plot,
    input  done, err, busy, sq_go, sq_x, sq_y, sq_colour, sq_draw
  );

  modport slave (
    input  req, req_x, req_y, req_colour, req_draw, sq_plot,
    output done, err, busy, sq_go, sq_x, sq_y, sq_colour, sq_draw
  );
endinterface

// File: rtl/square_draw_arbiter.sv
// Round-robin scheduler sharing one 4x4 square draw engine among NUM_REQ requesters.
// Optional job watchdog enabled by defining SQ_ARB_WATCHDOG_EN.
module square_draw_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WD_START = 8,
  parameter int WD_BUSY  = 32
) (
  input logic                  clk,
  input logic                  reset,
  square_draw_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WD_START < 1 || WD_START > 64 ||
      WD_BUSY < 1 || WD_BUSY > 64) begin : g_param_check
    $error("square_draw_arbiter: parameter out of range");
  end

  state_t        state, state_nx;
  logic [IW-1:0] ptr, owner, gnt_idx;
  logic          gnt_ok;
  logic          timeout;
  logic [7:0]    x_q;
  logic [6:0]    y_q;
  logic [2:0]    colour_q;
  logic          draw_q;
  logic [NUM_REQ-1:0] done_w;

  // Search upward from ptr with wrap; first asserted request wins.
  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    idx     = 0;
    cand    = '0;
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!gnt_ok && bus.req[cand]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_ok) state_nx = ISSUE;
      ISSUE:   if (bus.sq_plot) state_nx = BUSY;
               else if (timeout) state_nx = DONE;
      BUSY:    if (!bus.sq_plot || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      draw_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && gnt_ok) begin
        owner    <= gnt_idx;
        x_q      <= bus.req_x[8*gnt_idx +: 8];
        y_q      <= bus.req_y[7*gnt_idx +: 7];
        colour_q <= bus.req_colour[3*gnt_idx +: 3];
        draw_q   <= bus.req_draw[gnt_idx];
      end
      if (state == DONE)
        ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    end
  end

  always_comb begin
    done_w = '0;
    if (state == DONE) done_w[owner] = 1'b1;
  end

`ifdef SQ_ARB_WATCHDOG_EN
  logic [5:0] wd_cnt;
  logic       wd_err;

  // A plot edge arriving on the final allowed cycle still counts as a normal finish.
  assign timeout = (state == ISSUE && !bus.sq_plot && wd_cnt == 6'(WD_START - 1)) ||
                   (state == BUSY  &&  bus.sq_plot && wd_cnt == 6'(WD_BUSY - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state_nx != state)
        wd_cnt <= '0;
      else if (state == ISSUE || state == BUSY)
        wd_cnt <= wd_cnt + 6'd1;
      if (state_nx == DONE && state != DONE)
        wd_err <= timeout;
    end
  end

  assign bus.err = (state == DONE) && wd_err;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.done      = done_w;
  assign bus.busy      = (state != IDLE);
  assign bus.sq_go     = (state == ISSUE);
  assign bus.sq_x      = x_q;
  assign bus.sq_y      = y_q;
  assign bus.sq_colour = colour_q;
  assign bus.sq_draw   = draw_q;
endmodule

// File: tb/tb_square_draw_arbiter.sv
// Directed self-checking bench for square_draw_arbiter (4 requesters).
module tb_square_draw_arbiter;
  localparam int NREQ = 4;
  localparam int WDS  = 8;
  localparam int WDB  = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] xv [NREQ];
  logic [6:0] yv [NREQ];
  logic [2:0] cv [NREQ];
  logic       dv [NREQ];

  square_draw_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  square_draw_arbiter #(
    .NUM_REQ (NREQ),
    .WD_START(WDS),
    .WD_BUSY (WDB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[8*i +: 8]      = xv[i];
      bus.req_y[7*i +: 7]      = yv[i];
      bus.req_colour[3*i +: 3] = cv[i];
      bus.req_draw[i]          = dv[i];
    end
  endtask

  // Called at a negedge in IDLE with the request(s) already presented.
  task automatic job(input int own, input logic [3:0] drop, input bit mutate);
    @(negedge clk);
    check("go_rise", 32'(bus.sq_go), 32'd1);
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("sq_x", 32'(bus.sq_x), 32'(xv[own]));
    check("sq_y", 32'(bus.sq_y), 32'(yv[own]));
    check("sq_colour", 32'(bus.sq_colour), 32'(cv[own]));
    check("sq_draw", 32'(bus.sq_draw), 32'(dv[own]));
    @(negedge clk);
    check("go_hold", 32'(bus.sq_go), 32'd1);
    bus.sq_plot = 1'b1;
    @(negedge clk);
    check("go_fall", 32'(bus.sq_go), 32'd0);
    check("busy_mid", 32'(bus.busy), 32'd1);
    if (mutate) begin
      bus.req_x[8*own +: 8] = 8'd99;
      bus.req[own]          = 1'b0;
    end
    repeat (15) @(negedge clk);
    check("done_early", 32'(bus.done), 32'd0);
    bus.sq_plot = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'(4'b0001 << own));
    check("err_clean", 32'(bus.err), 32'd0);
    check("sq_x_held", 32'(bus.sq_x), 32'(xv[own]));
    bus.req = bus.req & ~drop;
    @(negedge clk);
    check("done_once", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    xv[0] = 8'd10;  yv[0] = 7'd20;  cv[0] = 3'b101; dv[0] = 1'b1;
    xv[1] = 8'd40;  yv[1] = 7'd5;   cv[1] = 3'b010; dv[1] = 1'b0;
    xv[2] = 8'd77;  yv[2] = 7'd100; cv[2] = 3'b111; dv[2] = 1'b1;
    xv[3] = 8'd200; yv[3] = 7'd127; cv[3] = 3'b001; dv[3] = 1'b0;
    reset       = 1'b1;
    bus.req     = '0;
    bus.sq_plot = 1'b0;
    load_data();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_go", 32'(bus.sq_go), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_sq_x", 32'(bus.sq_x), 32'd0);
    check("rst_sq_y", 32'(bus.sq_y), 32'd0);
    check("rst_sq_colour", 32'(bus.sq_colour), 32'd0);
    check("rst_sq_draw", 32'(bus.sq_draw), 32'd0);
    reset = 1'b0;

    // Single request from requester 0
    @(negedge clk);
    bus.req = 4'b0001;
    job(0, 4'b0001, 1'b0);

    // Re-reset so the pointer starts at 0, then all four continuously
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++)
      job(k % 4, (k == 7) ? 4'b1111 : 4'b0000, 1'b0);

    // Pointer wrap: serve 1 (ptr -> 2), then 0011 must pick 0 before 1
    bus.req = 4'b0010;
    job(1, 4'b0010, 1'b0);
    bus.req = 4'b0011;
    job(0, 4'b0001, 1'b0);
    job(1, 4'b0010, 1'b0);

    // Data change and req drop after grant are ignored
    bus.req = 4'b0100;
    job(2, 4'b0000, 1'b1);
    load_data();

    // Reset asserted mid-job during BUSY
    bus.req = 4'b1000;
    @(negedge clk);
    check("abort_go", 32'(bus.sq_go), 32'd1);
    @(negedge clk);
    bus.sq_plot = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy_low", 32'(bus.busy), 32'd0);
    check("abort_go_low", 32'(bus.sq_go), 32'd0);
    check("abort_done_low", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("abort_no_done", 32'(bus.done), 32'd0);
    reset       = 1'b0;
    bus.sq_plot = 1'b0;
    bus.req     = 4'b1001;
    job(0, 4'b0001, 1'b0);
    job(3, 4'b1000, 1'b0);

`ifdef SQ_ARB_WATCHDOG_EN
    bus.req = 4'b0001;
    @(negedge clk);
    check("wd_go", 32'(bus.sq_go), 32'd1);
    for (int i = 1; i < WDS; i++) begin
      @(negedge clk);
      check("wd_wait", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check("wd_done", 32'(bus.done), 32'd1);
    check("wd_err", 32'(bus.err), 32'd1);
    bus.req = 4'b0000;
    @(negedge clk);
    check("wd_idle", 32'(bus.busy), 32'd0);
    check("wd_err_clear", 32'(bus.err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/square_draw_arbiter.md
# square_draw_arbiter

Round-robin scheduler that shares a single 4x4 square draw engine between NUM_REQ requesters, such as note lanes, the judgement marker and score blocks. It accepts one draw or erase job per requester and latches its coordinates, colour and draw flag. It then starts the engine with `sq_go`, tracks the engine's `sq_plot` window, and returns a one-cycle `done` to the requester that owned the job. It sits between the game logic and the square engine/datapath pair feeding the VGA adapter.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WD_START, 8, watchdog cycles allowed in ISSUE (watchdog build only)
- WD_BUSY, 32, watchdog cycles allowed in BUSY (watchdog build only)

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- req  in  NUM_REQ  per-requester job request, level
- req_x  in  8*NUM_REQ  square x origin, requester i at [8i+7:8i]
- req_y  in  7*NUM_REQ  square y origin, requester i at [7i+6:7i]
- req_colour  in  3*NUM_REQ  colour, requester i at [3i+2:3i]
- req_draw  in  NUM_REQ  1 = draw in colour, 0 = erase to black
- done  out  NUM_REQ  one-cycle completion pulse to the job owner
- err  out  1  one-cycle pulse with `done` when the watchdog aborted the job; constant 0 without the watchdog
- busy  out  1  high in every state other than IDLE
- sq_go  out  1  start request to the square engine
- sq_plot  in  1  engine plot output, high while pixels are emitted
- sq_x  out  8  latched x origin to the datapath
- sq_y  out  7  latched y origin to the datapath
- sq_colour  out  3  latched colour to the datapath
- sq_draw  out  1  latched draw flag to the datapath

## Operation
- State machine states: IDLE, ISSUE, BUSY, DONE.
- IDLE
  - Samples `req`. Only requests present in IDLE are considered.
  - Grant goes to the first asserted `req[i]` searching upward, with wrap, from pointer `ptr`.
  - On grant: latch the owner index and `req_x/y/colour/draw[i]` into the `sq_*` registers, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE
  - `sq_go` = 1.
  - When `sq_plot` = 1 is sampled, go to BUSY.
- BUSY
  - `sq_go` = 0.
  - When `sq_plot` = 0 is sampled, go to DONE.
- DONE
  - `done[owner]` = 1 for exactly this cycle.
  - `ptr` <= owner+1 modulo NUM_REQ.
  - Next state is IDLE.
- `sq_x/y/colour/draw` are stable from the grant edge until the next grant; they are never driven from live `req_*` inputs.
- A requester holds `req` until it sees `done` and must drop it by the edge ending the `done` cycle. If `req` is still high in the following IDLE cycle, that counts as a new job.
- Dropping `req` after grant does not cancel the job; `done` still pulses.
- Changes on `req_*` data after grant are ignored.
- Fairness: with all requesters continuously asserting, each requester receives exactly one grant per NUM_REQ jobs.
- `sq_plot` high while in IDLE, which should not occur, is ignored.

## Timing
- Reset state, asynchronous:
  - State = IDLE, `ptr` = 0, owner = 0.
  - `done` = 0, `err` = 0, `busy` = 0, `sq_go` = 0.
  - `sq_x` = 0, `sq_y` = 0, `sq_colour` = 0, `sq_draw` = 0.
- Reset asserted mid-job: return to IDLE at once; no `done` is issued; `sq_go` drops asynchronously. The engine is expected to share the same reset.
- All outputs are registered or decoded purely from state, with no combinational path from `req` to any output.
- Grant latency: `req` is sampled high in IDLE at cycle t; `busy` and `sq_go` go high in cycle t+1.
- `sq_go` stays high until `sq_plot` is sampled high, so the engine cannot miss the start. It falls in the first BUSY cycle, which is before the 16-cycle plot window ends, so the engine is never re-triggered.
- `done` is high in the cycle after the first low sample of `sq_plot`. `busy` falls one cycle after `done`.
- Job length with the 4x4 engine is about 16 plot cycles plus engine start latency plus 3 arbiter cycles. The minimum gap between the `done` of one job and the `sq_go` of the next is 1 cycle (the IDLE cycle).

## Configuration
- Macro SQ_ARB_WATCHDOG_EN.
- Defined:
  - A 6-bit counter clears on every state entry and increments each cycle in ISSUE and BUSY.
  - If ISSUE lasts WD_START cycles without `sq_plot`, or BUSY lasts WD_BUSY cycles without `sq_plot` falling, go to DONE.
  - In that DONE cycle, `done[owner]` = 1 and `err` = 1. The pointer advances as normal.
- Undefined: no counter; ISSUE and BUSY wait indefinitely; `err` is tied to 0.

## Test plan
- Reset, then single request: `req` = 0001, x = 10, y = 20, colour = 3'b101, draw = 1.
  - `sq_go` high one cycle later; `sq_x/y/colour/draw` = 10/20/101/1.
  - Exactly one `done[0]` pulse after the engine's 16 plot cycles; `busy` = 0 afterwards.
- All four requesters asserted continuously for 8 jobs: grant order is 0,1,2,3,0,1,2,3; each requester sees one `done` pulse per job.
- With `ptr` = 2 after serving requester 1, assert `req` = 0011: requester 0 is granted before requester 1 (wrap from index 2).
- Change `req_x` of the owner to 99 and drop its `req` during BUSY: `sq_x` keeps its latched value, and `done` still pulses for that owner.
- Assert `reset` during BUSY: `busy`, `sq_go` and `done` are 0 immediately; the next request after reset is served with `ptr` = 0.
- SQ_ARB_WATCHDOG_EN defined and `sq_plot` tied to 0: `done[owner]` and `err` are high together WD_START cycles after `sq_go` rises, then the block returns to IDLE.
